// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the masked, self-initialising 1RW SRAM model.
//   state_e  : init sequencer state (INIT sweep / IDLE serving requests)
//   addr_w   : address width for a given depth (at least 1 bit)
//   mask_seg : number of write-mask granules for a given data width and granule size
package sram_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_e;

   function automatic int addr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int mask_seg(input int width, input int gran);
      return width / gran;
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset init sweep sequencer. Walks every entry once, asserting init_we with
// init_addr, then parks in IDLE with ready high until the next reset.
//   clk       in  clock, rising edge
//   reset     in  synchronous active-high reset
//   init_we   out write INIT_VALUE to init_addr this cycle
//   init_addr out entry being initialised
//   ready     out sweep finished, port requests may be accepted
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | sweeping, one entry written per cycle, port requests ignored
// IDLE  | sweep done, array serves port requests
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output logic              ready
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         IDLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      init_we   = (state_q == INIT);
      init_addr = cnt_q;
      ready     = (state_q == IDLE);
   end

endmodule

// File: rtl/sram_1rw_masked_init.sv
// Single-port (1RW) SRAM model with per-granule write mask, 1- or 2-cycle read latency,
// read-valid pulse, held read data and a hardware init sweep after reset.
//   RW0_clk    in  clock, rising edge
//   RW0_reset  in  synchronous active-high reset
//   RW0_en     in  request valid (taken only while RW0_ready)
//   RW0_wmode  in  1 = write, 0 = read
//   RW0_addr   in  entry index
//   RW0_wdata  in  write data
//   RW0_wmask  in  per-granule write enables
//   RW0_ready  out init sweep complete
//   RW0_rvalid out one-cycle pulse with each new read result
//   RW0_rdata  out read data, held between results
module sram_1rw_masked_init
   import sram_pkg::*;
#(
   parameter int               DEPTH        = 16384,
   parameter int               WIDTH        = 64,
   parameter int               MASK_GRAN    = 8,
   parameter int               READ_LATENCY = 1,
   parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
   localparam int              ADDR_W       = addr_w(DEPTH),
   localparam int              MASK_SEG     = mask_seg(WIDTH, MASK_GRAN)
) (
   input  logic                RW0_clk,
   input  logic                RW0_reset,
   input  logic                RW0_en,
   input  logic                RW0_wmode,
   input  logic [ADDR_W-1:0]   RW0_addr,
   input  logic [WIDTH-1:0]    RW0_wdata,
   input  logic [MASK_SEG-1:0] RW0_wmask,
   output logic                RW0_ready,
   output logic                RW0_rvalid,
   output logic [WIDTH-1:0]    RW0_rdata
);

   if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $error("sram_1rw_masked_init: WIDTH must be a multiple of MASK_GRAN");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("sram_1rw_masked_init: READ_LATENCY must be 1 or 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("sram_1rw_masked_init: DEPTH must be at least 2");
   end

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic              ready;

   sram_init_seq #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_init_seq (
      .clk      (RW0_clk),
      .reset    (RW0_reset),
      .init_we  (init_we),
      .init_addr(init_addr),
      .ready    (ready)
   );

   assign RW0_ready = ready;

   // Extra bit so a power-of-two DEPTH is representable in the compare.
   logic addr_ok;
   assign addr_ok = ({1'b0, RW0_addr} < (ADDR_W + 1)'(DEPTH));

   // A request coinciding with reset is dropped so nothing survives into the new sweep.
   logic req_ok, port_we, rd_acc;
   assign req_ok  = RW0_en & ready & ~RW0_reset;
   assign port_we = req_ok & RW0_wmode & addr_ok;
   assign rd_acc  = req_ok & ~RW0_wmode;

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WIDTH-1:0]    mem_wdata;
   logic [MASK_SEG-1:0] mem_seg;

   // init_we and port_we are exclusive: ready is low for the whole sweep.
   always_comb begin
      mem_we    = init_we | port_we;
      mem_addr  = init_we ? init_addr  : RW0_addr;
      mem_wdata = init_we ? INIT_VALUE : RW0_wdata;
      mem_seg   = init_we ? '1         : RW0_wmask;
   end

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge RW0_clk) begin
      if (mem_we) begin
         for (int i = 0; i < MASK_SEG; i++) begin
            if (mem_seg[i]) begin
               mem_q[mem_addr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
         end
      end
   end

   // Read samples the array before a same-edge write lands, so in-flight reads see old data.
   logic [WIDTH-1:0] mem_rdata;
   assign mem_rdata = addr_ok ? mem_q[RW0_addr] : '0;

   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_dat_q, s1_dat_d;
   logic             rvalid_q, rvalid_d;
   logic [WIDTH-1:0] rdata_q,  rdata_d;

   always_comb begin
      s1_vld_d = rd_acc;
      s1_dat_d = rd_acc ? mem_rdata : s1_dat_q;
      if (READ_LATENCY == 2) begin
         rvalid_d = s1_vld_q;
         rdata_d  = s1_vld_q ? s1_dat_q : rdata_q;
      end else begin
         rvalid_d = rd_acc;
         rdata_d  = rd_acc ? mem_rdata : rdata_q;
      end
   end

   always_ff @(posedge RW0_clk) begin
      if (RW0_reset) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_dat_q <= s1_dat_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign RW0_rvalid = rvalid_q;
   assign RW0_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
module tb_sram_1rw_masked_init;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wmode;
   logic [3:0]  addr;
   logic [63:0] wdata;
   logic [7:0]  wmask;

   logic        rdy_1, rv_1;
   logic [63:0] rd_1;
   logic        rdy_2, rv_2;
   logic [63:0] rd_2;
   logic        rdy_c, rv_c;
   logic [63:0] rd_c;
   logic        rdy_o, rv_o;
   logic [63:0] rd_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_1rw_masked_init #(.DEPTH(16), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                          .INIT_VALUE(64'h0)) u_lat1 (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
      .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_ready(rdy_1), .RW0_rvalid(rv_1), .RW0_rdata(rd_1));

   sram_1rw_masked_init #(.DEPTH(16), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(2),
                          .INIT_VALUE(64'h0)) u_lat2 (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
      .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_ready(rdy_2), .RW0_rvalid(rv_2), .RW0_rdata(rd_2));

   sram_1rw_masked_init #(.DEPTH(16), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                          .INIT_VALUE(64'hCAFE)) u_cafe (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
      .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_ready(rdy_c), .RW0_rvalid(rv_c), .RW0_rdata(rd_c));

   sram_1rw_masked_init #(.DEPTH(12), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                          .INIT_VALUE(64'h0)) u_odd (
      .RW0_clk(clk), .RW0_reset(rst), .RW0_en(en), .RW0_wmode(wmode), .RW0_addr(addr),
      .RW0_wdata(wdata), .RW0_wmask(wmask), .RW0_ready(rdy_o), .RW0_rvalid(rv_o), .RW0_rdata(rd_o));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
      en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
      tick();
      en = 1'b0; wmode = 1'b0;
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [63:0] e0, input logic [63:0] ec);
      en = 1'b1; wmode = 1'b0; addr = a;
      tick();
      en = 1'b0;
      chk("l1_rvalid",   rv_1, 64'd1);
      chk("l1_rdata",    rd_1, e0);
      chk("l2_early",    rv_2, 64'd0);
      chk("cafe_rvalid", rv_c, 64'd1);
      chk("cafe_rdata",  rd_c, ec);
      tick();
      chk("l1_pulse",    rv_1, 64'd0);
      chk("l2_rvalid",   rv_2, 64'd1);
      chk("l2_rdata",    rd_2, e0);
   endtask

   task automatic reset_sweep(input string tag);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         chk({tag, "_ready_low"}, {rdy_1, rdy_2, rdy_c}, 64'd0);
         chk({tag, "_rvalid_low"}, {rv_1, rv_2, rv_c}, 64'd0);
         tick();
      end
      chk({tag, "_ready_high"}, {rdy_1, rdy_2, rdy_c}, 64'h7);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wdata = '0; wmask = '0;

      // 1: reset, sweep length, every entry initialised
      tick();
      rst = 1'b0;
      chk("rst_rdata", rd_1, 64'd0);
      chk("rst_rdata_l2", rd_2, 64'd0);
      for (int i = 1; i <= 16; i++) begin
         chk("t1_ready_low", rdy_1, 64'd0);
         tick();
      end
      chk("t1_ready_high", {rdy_1, rdy_2, rdy_c}, 64'h7);
      for (int a = 0; a < 16; a++) rd_chk(4'(a), 64'd0, 64'hCAFE);

      // 2: masked write merge and latency
      wr(4'd3, 64'h1122334455667788, 8'hFF);
      wr(4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      rd_chk(4'd3, 64'h11223344FFFFFFFF, 64'h11223344FFFFFFFF);

      // 3: back-to-back reads and hold; wmask=0 no-op
      wr(4'd0, 64'hA, 8'hFF);
      wr(4'd1, 64'hB, 8'hFF);
      wr(4'd2, 64'hC, 8'hFF);
      wr(4'd2, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      en = 1'b1; wmode = 1'b0; addr = 4'd0;
      tick();
      chk("b2b_l1_0", {63'd0, rv_1}, 64'd1); chk("b2b_l1_d0", rd_1, 64'hA);
      addr = 4'd1;
      tick();
      chk("b2b_l1_1", {63'd0, rv_1}, 64'd1); chk("b2b_l1_d1", rd_1, 64'hB);
      chk("b2b_l2_0", {63'd0, rv_2}, 64'd1); chk("b2b_l2_d0", rd_2, 64'hA);
      addr = 4'd2;
      tick();
      en = 1'b0;
      chk("b2b_l1_2", {63'd0, rv_1}, 64'd1); chk("b2b_l1_d2", rd_1, 64'hC);
      chk("b2b_l2_1", {63'd0, rv_2}, 64'd1); chk("b2b_l2_d1", rd_2, 64'hB);
      tick();
      chk("b2b_l1_end", {63'd0, rv_1}, 64'd0);
      chk("b2b_l2_2", {63'd0, rv_2}, 64'd1); chk("b2b_l2_d2", rd_2, 64'hC);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_rvalid", {rv_1, rv_2}, 64'd0);
         chk("hold_l1", rd_1, 64'hC);
         chk("hold_l2", rd_2, 64'hC);
      end

      // 4: writes during init are ignored
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b1; wmode = 1'b1; addr = 4'd5; wdata = 64'hDEAD; wmask = 8'hFF;
      for (int i = 1; i <= 16; i++) begin
         chk("t4_ready_low", rdy_1, 64'd0);
         chk("t4_no_rvalid", {rv_1, rv_2}, 64'd0);
         tick();
      end
      en = 1'b0; wmode = 1'b0;
      chk("t4_ready_high", rdy_1, 64'd1);
      rd_chk(4'd5, 64'd0, 64'hCAFE);

      // 5: reset with a LAT=2 read in flight
      wr(4'd7, 64'h55, 8'hFF);
      en = 1'b1; wmode = 1'b0; addr = 4'd7;
      tick();
      en = 1'b0;
      chk("t5_l1_rvalid", {63'd0, rv_1}, 64'd1);
      chk("t5_l1_rdata", rd_1, 64'h55);
      reset_sweep("t5");
      chk("t5_l2_rdata", rd_2, 64'd0);
      chk("t5_l1_rdata0", rd_1, 64'd0);
      for (int a = 0; a < 16; a++) rd_chk(4'(a), 64'd0, 64'hCAFE);

      // out-of-range addresses on a non-power-of-two depth
      wr(4'd11, 64'h77, 8'hFF);
      wr(4'd13, 64'h1234, 8'hFF);
      en = 1'b1; wmode = 1'b0; addr = 4'd11;
      tick();
      chk("odd_rv_11", {63'd0, rv_o}, 64'd1); chk("odd_rd_11", rd_o, 64'h77);
      addr = 4'd13;
      tick();
      chk("odd_rv_13", {63'd0, rv_o}, 64'd1); chk("odd_rd_13", rd_o, 64'd0);
      addr = 4'd12;
      tick();
      en = 1'b0;
      chk("odd_rv_12", {63'd0, rv_o}, 64'd1); chk("odd_rd_12", rd_o, 64'd0);
      tick();
      chk("odd_rv_end", {63'd0, rv_o}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
